// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 constants, types and helpers shared by the FP unit (fdiv16_iter, fma16).
// FDIV16_SUBNORM_EN: when defined, fp16_unpack normalizes subnormal operands instead of flushing them.
package fp16_pkg;

    localparam int BIAS  = 15;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] MAX_FIN = 16'h7BFF;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RP  = 2'b10,
        RM_RN  = 2'b11
    } roundmode_e;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef struct packed {
        logic               nan;
        logic               snan;
        logic               inf;
        logic               zero;
        logic [10:0]        sig;
        logic signed [6:0]  ex;
    } fp16_unp_t;

    function automatic logic [3:0] lzc10(input logic [9:0] m);
        logic [3:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (!hit) begin
                if (m[9 - i]) hit = 1'b1;
                else          n   = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Sign is handled by the caller; ex is the biased exponent, signed so subnormals can go below 1.
    function automatic fp16_unp_t fp16_unpack(input logic [14:0] v);
        fp16_unp_t        u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e      = v[14:10];
        m      = v[9:0];
        u.nan  = (&e) & (|m);
        u.snan = u.nan & ~m[9];
        u.inf  = (&e) & ~(|m);
`ifdef FDIV16_SUBNORM_EN
        u.zero = (e == '0) && (m == '0);
        if (e == '0) begin
            u.sig = {1'b0, m} << (lzc10(m) + 4'd1);
            u.ex  = -$signed({3'b000, lzc10(m)});
        end else begin
            u.sig = {1'b1, m};
            u.ex  = $signed({2'b00, e});
        end
`else
        u.zero = (e == '0);
        u.sig  = {1'b1, m};
        u.ex   = $signed({2'b00, e});
`endif
        return u;
    endfunction

endpackage

// File: rtl/fp16_round.sv
// fp16_round: combinational binary16 rounding/packing with overflow saturation per roundmode.
// Caller passes exponent 0 with a hidden-bit-clear significand for subnormal results.
module fp16_round
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic [10:0]       sig,
    input  logic              guard,
    input  logic              sticky,
    input  logic signed [6:0] exponent,
    input  logic [1:0]        roundmode,
    output logic [15:0]       result,
    output logic              of,
    output logic              nx
);

    roundmode_e  rm;
    logic        inc;
    logic        inf_sel;
    logic [14:0] sum;

    always_comb begin
        rm = roundmode_e'(roundmode);
        case (rm)
            RM_RZ:   inc = 1'b0;
            RM_RNE:  inc = guard & (sticky | sig[0]);
            RM_RP:   inc = ~sign & (guard | sticky);
            default: inc = sign & (guard | sticky);
        endcase

        // Hidden bit is folded into the exponent field so a mantissa carry bumps the exponent for free.
        sum = {exponent[4:0] - {4'b0000, sig[10]}, 10'b0} + {4'b0000, sig} + 15'(inc);

        of      = (exponent > 7'sd30) | (sum[14:10] == 5'h1F);
        nx      = guard | sticky | of;
        inf_sel = (rm == RM_RNE) | ((rm == RM_RP) & ~sign) | ((rm == RM_RN) & sign);

        if (of) result = {sign, inf_sel ? POS_INF[14:0] : MAX_FIN[14:0]};
        else    result = {sign, sum};
    end

endmodule

// File: rtl/fdiv16_iter.sv
// fdiv16_iter: iterative radix-2 restoring binary16 divider, one quotient bit per cycle.
// FDIV16_SUBNORM_EN: enables subnormal operands and gradual-underflow results.
module fdiv16_iter
    import fp16_pkg::*;
#(
    parameter logic [15:0] CANON_NAN = 16'h7E00,
    parameter int          QBITS     = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  flags
);

    logic [2:0]        state_q, state_d;
    logic [15:0]       xa_q, xa_d, ya_q, ya_d;
    logic [1:0]        rm_q, rm_d;
    logic              sign_q, sign_d;
    logic signed [6:0] exp_q, exp_d;
    logic [10:0]       dv_q, dv_d;
    logic [11:0]       rem_q, rem_d;
    logic [12:0]       quo_q, quo_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       result_q, result_d;
    logic [4:0]        flags_q, flags_d;

    fp16_unp_t         xu, yu;
    logic              s_prep;
    logic [12:0]       trial;
    logic              q_bit;

    logic [10:0]       r_sig, rd_sig;
    logic              r_g, rd_g, r_st, rd_st;
    logic signed [6:0] r_e, rd_e;
    logic              tiny;
    logic [15:0]       rnd_res;
    logic              rnd_of, rnd_nx;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign flags     = flags_q;

    assign xu     = fp16_unpack(xa_q[14:0]);
    assign yu     = fp16_unpack(ya_q[14:0]);
    assign s_prep = xa_q[15] ^ ya_q[15];

    assign trial = {1'b0, rem_q} - {2'b00, dv_q};
    assign q_bit = ~trial[12];

    // Normalize the quotient: an MSB of 0 means x_sig < y_sig, so take one more bit and drop the exponent.
    always_comb begin
        r_sig = quo_q[12] ? quo_q[12:2] : quo_q[11:1];
        r_g   = quo_q[12] ? quo_q[1]    : quo_q[0];
        r_st  = (quo_q[12] & quo_q[0]) | (rem_q != '0);
        r_e   = quo_q[12] ? exp_q : exp_q - 7'sd1;
        tiny  = (r_e <= 7'sd0);
    end

`ifdef FDIV16_SUBNORM_EN
    logic signed [6:0] sh_full;
    logic [3:0]        sh;
    logic [23:0]       ext;

    // Denormalize before rounding; a shift of 12 already pushes every bit below the guard position.
    always_comb begin
        sh_full = 7'sd1 - r_e;
        sh      = (sh_full > 7'sd12) ? 4'd12 : sh_full[3:0];
        ext     = {r_sig, r_g, 12'b0} >> (tiny ? sh : 4'd0);
        rd_sig  = ext[23:13];
        rd_g    = ext[12];
        rd_st   = r_st | (|ext[11:0]);
        rd_e    = tiny ? 7'sd0 : r_e;
    end
`else
    assign rd_sig = r_sig;
    assign rd_g   = r_g;
    assign rd_st  = r_st;
    assign rd_e   = r_e;
`endif

    fp16_round u_round (
        .sign      (sign_q),
        .sig       (rd_sig),
        .guard     (rd_g),
        .sticky    (rd_st),
        .exponent  (rd_e),
        .roundmode (rm_q),
        .result    (rnd_res),
        .of        (rnd_of),
        .nx        (rnd_nx)
    );

    always_comb begin
        state_d  = state_q;
        xa_d     = xa_q;
        ya_d     = ya_q;
        rm_d     = rm_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        dv_d     = dv_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xa_d    = x;
                    ya_d    = y;
                    rm_d    = roundmode;
                    state_d = S_PREP;
                end
            end

            S_PREP: begin
                sign_d  = s_prep;
                exp_d   = xu.ex - yu.ex + 7'(BIAS);
                dv_d    = yu.sig;
                rem_d   = {1'b0, xu.sig};
                quo_d   = '0;
                cnt_d   = 4'(QBITS - 1);
                flags_d = '0;
                state_d = S_DONE;
                if (xu.nan | yu.nan) begin
                    result_d         = CANON_NAN;
                    flags_d[FLAG_NV] = xu.snan | yu.snan;
                end else if ((xu.zero & yu.zero) | (xu.inf & yu.inf)) begin
                    result_d         = CANON_NAN;
                    flags_d[FLAG_NV] = 1'b1;
                end else if (xu.inf) begin
                    result_d = {s_prep, POS_INF[14:0]};
                end else if (yu.zero) begin
                    result_d         = {s_prep, POS_INF[14:0]};
                    flags_d[FLAG_DZ] = 1'b1;
                end else if (xu.zero | yu.inf) begin
                    result_d = {s_prep, 15'b0};
                end else begin
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                quo_d = {quo_q[11:0], q_bit};
                rem_d = (q_bit ? trial[11:0] : rem_q) << 1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == '0) state_d = S_ROUND;
            end

            S_ROUND: begin
                flags_d = '0;
`ifdef FDIV16_SUBNORM_EN
                result_d         = rnd_res;
                flags_d[FLAG_OF] = rnd_of;
                flags_d[FLAG_UF] = tiny & rnd_nx;
                flags_d[FLAG_NX] = rnd_nx;
`else
                if (tiny) begin
                    result_d         = {sign_q, 15'b0};
                    flags_d[FLAG_UF] = 1'b1;
                    flags_d[FLAG_NX] = 1'b1;
                end else begin
                    result_d         = rnd_res;
                    flags_d[FLAG_OF] = rnd_of;
                    flags_d[FLAG_NX] = rnd_nx;
                end
`endif
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            xa_q     <= '0;
            ya_q     <= '0;
            rm_q     <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            dv_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            xa_q     <= xa_d;
            ya_q     <= ya_d;
            rm_q     <= rm_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            dv_q     <= dv_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fdiv16_iter.sv
// tb_fdiv16_iter: directed-vector self-checking bench for fdiv16_iter (default build).
// Latency is counted in clock edges with the accept edge as edge 1.
module tb_fdiv16_iter;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RP  = 2'b10;
    localparam logic [1:0] RN  = 2'b11;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NV   = 5'b10000;
    localparam logic [4:0] F_DZ   = 5'b01000;
    localparam logic [4:0] F_OFNX = 5'b00101;
    localparam logic [4:0] F_UFNX = 5'b00011;
    localparam logic [4:0] F_NX   = 5'b00001;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  roundmode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_total = 0;
    int n_bad   = 0;

    fdiv16_iter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .roundmode (roundmode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm);
        @(negedge clk);
        x         = a;
        y         = b;
        roundmode = rm;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        x         = 16'hFFFF;
        y         = 16'hFFFF;
        roundmode = ~rm;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_res(input string tag, input logic [15:0] er, input logic [4:0] ef, input int el);
        int lat;
        wait_valid(lat);
        chk({tag, "/valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/res"}, 32'(result), 32'(er));
        chk({tag, "/flags"}, 32'(flags), 32'(ef));
        if (el != 0) chk({tag, "/lat"}, lat, el);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/clr"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] rm, input logic [15:0] er, input logic [4:0] ef,
                         input int el);
        issue(a, b, rm);
        wait_res(tag, er, ef, el);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        roundmode = RNE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/res", 32'(result), 32'h0);
        chk("rst/flags", 32'(flags), 32'h0);
        chk("rst/valid", 32'(out_valid), 32'd0);
        chk("rst/ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        do_op("half",      16'h3C00, 16'h4000, RNE, 16'h3800, F_NONE, 16);
        do_op("third_rne", 16'h3C00, 16'h4200, RNE, 16'h3555, F_NX,   16);
        do_op("third_rz",  16'h3C00, 16'h4200, RZ,  16'h3555, F_NX,   0);
        do_op("third_rp",  16'h3C00, 16'h4200, RP,  16'h3556, F_NX,   0);
        do_op("third_rn",  16'h3C00, 16'h4200, RN,  16'h3555, F_NX,   0);
        do_op("ten3_rne",  16'h4900, 16'h4200, RNE, 16'h42AB, F_NX,   0);
        do_op("ten3_rz",   16'h4900, 16'h4200, RZ,  16'h42AA, F_NX,   0);
        do_op("neg",       16'hC000, 16'h4000, RNE, 16'hBC00, F_NONE, 0);
        do_op("zz",        16'h0000, 16'h0000, RNE, 16'h7E00, F_NV,   2);
        do_op("dz_pos",    16'h3C00, 16'h0000, RNE, 16'h7C00, F_DZ,   2);
        do_op("dz_neg",    16'hBC00, 16'h0000, RNE, 16'hFC00, F_DZ,   2);
        do_op("of_rne",    16'h7BFF, 16'h3800, RNE, 16'h7C00, F_OFNX, 16);
        do_op("of_rz",     16'h7BFF, 16'h3800, RZ,  16'h7BFF, F_OFNX, 0);
        do_op("of_rp_neg", 16'hFBFF, 16'h3800, RP,  16'hFBFF, F_OFNX, 0);
        do_op("of_rn_neg", 16'hFBFF, 16'h3800, RN,  16'hFC00, F_OFNX, 0);
        do_op("inf_fin",   16'h7C00, 16'h3C00, RNE, 16'h7C00, F_NONE, 2);
        do_op("inf_inf",   16'h7C00, 16'h7C00, RNE, 16'h7E00, F_NV,   0);
        do_op("snan",      16'h7D00, 16'h3C00, RNE, 16'h7E00, F_NV,   0);
        do_op("qnan",      16'h7E00, 16'h3C00, RNE, 16'h7E00, F_NONE, 0);
        do_op("fin_inf",   16'h3C00, 16'h7C00, RNE, 16'h0000, F_NONE, 0);
        do_op("uf",        16'h0400, 16'h7800, RNE, 16'h0000, F_UFNX, 0);
        do_op("sub_in",    16'h0200, 16'h3C00, RNE, 16'h0000, F_NONE, 2);

        // Output stall: result held, busy input ignored, next op accepted one cycle after handshake.
        issue(16'h3C00, 16'h4000, RNE);
        wait_valid(lat);
        chk("stall/valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        x         = 16'h4400;
        y         = 16'h4000;
        roundmode = RNE;
        in_valid  = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall/res", 32'(result), 32'h3800);
            chk("stall/flags", 32'(flags), 32'h0);
            chk("stall/ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stall/hs_valid", 32'(out_valid), 32'd0);
        chk("stall/hs_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = 16'hFFFF;
        y        = 16'hFFFF;
        chk("stall/acc_ready", 32'(in_ready), 32'd0);
        wait_res("after_stall", 16'h4000, F_NONE, 16);

        // Reset during DIV aborts the operation.
        issue(16'h3C00, 16'h4000, RNE);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort/valid", 32'(out_valid), 32'd0);
        chk("abort/ready", 32'(in_ready), 32'd1);
        do_op("post_abort", 16'h4400, 16'h4000, RNE, 16'h4000, F_NONE, 16);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
